// File: rtl/game_cmd_driver.sv
// game_cmd_driver: buffers host commands in a FIFO and issues each one to the
// game core only when the core is in the matching phase, then scores the
// core's response into saturating ok/err counters.
module game_cmd_driver #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_player,
    input  logic [1:0]               cmd_kind,
    input  logic [2:0]               cmd_code,
    input  logic                     phase_in,
    input  logic [1:0]               winner_in,
    input  logic                     purchase_success_p1,
    input  logic                     purchase_success_p2,
    input  logic                     err_no_inventory,
    input  logic                     err_wrong_distance,
    output logic                     turn,
    output logic                     play_valid,
    output logic [2:0]               play_action,
    output logic                     buy_valid_p1,
    output logic                     buy_valid_p2,
    output logic [2:0]               buy_code_p1,
    output logic [2:0]               buy_code_p2,
    output logic                     start_round,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               ok_count,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 6;

    localparam logic [1:0] K_PLAY  = 2'd0;
    localparam logic [1:0] K_BUY   = 2'd1;
    localparam logic [1:0] K_START = 2'd2;
    localparam logic [1:0] K_RSV   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP,
        S_WAIT_PH,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2:0]     cur_q, cur_d;          // {player, kind} of the command in flight
    logic           turn_q, turn_d;
    logic           play_valid_q, play_valid_d;
    logic [2:0]     play_action_q, play_action_d;
    logic           buy_valid_p1_q, buy_valid_p1_d;
    logic           buy_valid_p2_q, buy_valid_p2_d;
    logic [2:0]     buy_code_p1_q, buy_code_p1_d;
    logic [2:0]     buy_code_p2_q, buy_code_p2_d;
    logic           start_round_q, start_round_d;
    logic           done_q, done_d;
    logic [7:0]     ok_count_q, ok_count_d;
    logic [7:0]     err_count_q, err_count_d;

    logic           full, empty, push, pop, flush, ok_inc, err_inc, success;
    logic [EW-1:0]  head;
    logic           head_player;
    logic [1:0]     head_kind;
    logic [2:0]     head_code;
    logic           phase_ok;

    // FIFO status and head decode
    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        cmd_ready   = !full && (state_q != S_DONE);
        push        = cmd_valid && cmd_ready;
        head        = mem_q[rd_ptr_q];
        head_player = head[5];
        head_kind   = head[4:3];
        head_code   = head[2:0];
        busy        = (state_q != S_IDLE) || !empty;
        fifo_count  = count_q;
    end

    // Next-state, strobe and counter logic; a nonzero winner overrides everything
    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        turn_d         = turn_q;
        play_valid_d   = 1'b0;
        play_action_d  = play_action_q;
        buy_valid_p1_d = 1'b0;
        buy_valid_p2_d = 1'b0;
        buy_code_p1_d  = buy_code_p1_q;
        buy_code_p2_d  = buy_code_p2_q;
        start_round_d  = 1'b0;
        done_d         = done_q;
        pop            = 1'b0;
        flush          = 1'b0;
        ok_inc         = 1'b0;
        err_inc        = 1'b0;
        success        = 1'b0;
        phase_ok       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    phase_ok = ((head_kind == K_PLAY)  && !phase_in) ||
                               ((head_kind == K_BUY)   &&  phase_in) ||
                               ((head_kind == K_START) &&  phase_in);
                    if (head_kind == K_RSV) begin
                        pop     = 1'b1;
                        err_inc = 1'b1;
                    end else if (phase_ok) begin
                        pop     = 1'b1;
                        cur_d   = {head_player, head_kind};
                        state_d = S_ISSUE;
                        if (head_kind == K_PLAY) begin
                            play_valid_d  = 1'b1;
                            turn_d        = head_player;
                            play_action_d = head_code;
                        end else if (head_kind == K_BUY) begin
                            if (head_player) begin
                                buy_valid_p2_d = 1'b1;
                                buy_code_p2_d  = head_code;
                            end else begin
                                buy_valid_p1_d = 1'b1;
                                buy_code_p1_d  = head_code;
                            end
                        end else begin
                            start_round_d = 1'b1;
                        end
                    end
                end
            end
            S_ISSUE: begin
                state_d = (cur_q[1:0] == K_START) ? S_WAIT_PH : S_RESP;
            end
            S_RESP: begin
                if (cur_q[1:0] == K_BUY) begin
                    success = cur_q[2] ? purchase_success_p2 : purchase_success_p1;
                end else begin
                    success = !(err_no_inventory || err_wrong_distance);
                end
                ok_inc  = success;
                err_inc = !success;
                state_d = S_IDLE;
            end
            S_WAIT_PH: begin
                if (!phase_in) begin
                    ok_inc  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (winner_in != 2'd0) begin
            state_d        = S_DONE;
            done_d         = 1'b1;
            flush          = 1'b1;
            pop            = 1'b0;
            ok_inc         = 1'b0;
            err_inc        = 1'b0;
            play_valid_d   = 1'b0;
            buy_valid_p1_d = 1'b0;
            buy_valid_p2_d = 1'b0;
            start_round_d  = 1'b0;
        end

        ok_count_d  = (ok_inc  && (ok_count_q  != 8'hFF)) ? ok_count_q  + 8'd1 : ok_count_q;
        err_count_d = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    end

    // FIFO pointer and occupancy update; flush clears everything
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_player, cmd_kind, cmd_code};
        end
    end

    // State, pointer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            cur_q          <= '0;
            turn_q         <= 1'b0;
            play_valid_q   <= 1'b0;
            play_action_q  <= 3'd0;
            buy_valid_p1_q <= 1'b0;
            buy_valid_p2_q <= 1'b0;
            buy_code_p1_q  <= 3'd0;
            buy_code_p2_q  <= 3'd0;
            start_round_q  <= 1'b0;
            done_q         <= 1'b0;
            ok_count_q     <= 8'd0;
            err_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            cur_q          <= cur_d;
            turn_q         <= turn_d;
            play_valid_q   <= play_valid_d;
            play_action_q  <= play_action_d;
            buy_valid_p1_q <= buy_valid_p1_d;
            buy_valid_p2_q <= buy_valid_p2_d;
            buy_code_p1_q  <= buy_code_p1_d;
            buy_code_p2_q  <= buy_code_p2_d;
            start_round_q  <= start_round_d;
            done_q         <= done_d;
            ok_count_q     <= ok_count_d;
            err_count_q    <= err_count_d;
        end
    end

    assign turn         = turn_q;
    assign play_valid   = play_valid_q;
    assign play_action  = play_action_q;
    assign buy_valid_p1 = buy_valid_p1_q;
    assign buy_valid_p2 = buy_valid_p2_q;
    assign buy_code_p1  = buy_code_p1_q;
    assign buy_code_p2  = buy_code_p2_q;
    assign start_round  = start_round_q;
    assign done         = done_q;
    assign ok_count     = ok_count_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_game_cmd_driver.sv
// Scoreboard bench for game_cmd_driver: expected strobe events are queued as
// commands are pushed and a negedge monitor pops and compares each strobe.
module tb_game_cmd_driver;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_player;
    logic [1:0] cmd_kind;
    logic [2:0] cmd_code;
    logic       phase_in;
    logic [1:0] winner_in;
    logic       purchase_success_p1, purchase_success_p2;
    logic       err_no_inventory, err_wrong_distance;
    logic       turn, play_valid;
    logic [2:0] play_action;
    logic       buy_valid_p1, buy_valid_p2;
    logic [2:0] buy_code_p1, buy_code_p2;
    logic       start_round, busy, done;
    logic [7:0] ok_count, err_count;
    logic [$clog2(DEPTH):0] fifo_count;

    typedef struct packed {
        logic [1:0] kind;
        logic       player;
        logic [2:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  strobe_cnt = 0;

    game_cmd_driver #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_player(cmd_player), .cmd_kind(cmd_kind), .cmd_code(cmd_code),
        .phase_in(phase_in), .winner_in(winner_in),
        .purchase_success_p1(purchase_success_p1),
        .purchase_success_p2(purchase_success_p2),
        .err_no_inventory(err_no_inventory),
        .err_wrong_distance(err_wrong_distance),
        .turn(turn), .play_valid(play_valid), .play_action(play_action),
        .buy_valid_p1(buy_valid_p1), .buy_valid_p2(buy_valid_p2),
        .buy_code_p1(buy_code_p1), .buy_code_p2(buy_code_p2),
        .start_round(start_round), .busy(busy), .done(done),
        .ok_count(ok_count), .err_count(err_count), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe cycle must match the oldest queued expectation
    always @(negedge clk) begin : monitor
        ev_t obs;
        ev_t e;
        int  n;
        if (!rst && (play_valid || buy_valid_p1 || buy_valid_p2 || start_round)) begin
            strobe_cnt++;
            n = int'(play_valid) + int'(buy_valid_p1) + int'(buy_valid_p2) + int'(start_round);
            check("single_strobe", n, 1);
            if (play_valid)        obs = '{kind: 2'd0, player: turn, code: play_action};
            else if (buy_valid_p1) obs = '{kind: 2'd1, player: 1'b0, code: buy_code_p1};
            else if (buy_valid_p2) obs = '{kind: 2'd1, player: 1'b1, code: buy_code_p2};
            else                   obs = '{kind: 2'd2, player: 1'b0, code: 3'd0};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got event %0h expected none", obs);
            end else begin
                e = exp_q.pop_front();
                check("strobe_event", int'(obs), int'(e));
            end
        end
    end

    task automatic push(input logic p, input logic [1:0] k, input logic [2:0] c,
                        input bit expect_ev, output logic acc);
        ev_t ev;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_player = p;
        cmd_kind   = k;
        cmd_code   = c;
        acc        = cmd_ready;
        if (acc && expect_ev) begin
            ev = (k == 2'd2) ? '{kind: 2'd2, player: 1'b0, code: 3'd0}
                             : '{kind: k, player: p, code: c};
            exp_q.push_back(ev);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", int'(busy), 0);
    endtask

    task automatic check_reset();
        check("rst_turn", int'(turn), 0);
        check("rst_play_valid", int'(play_valid), 0);
        check("rst_play_action", int'(play_action), 0);
        check("rst_buy_valid_p1", int'(buy_valid_p1), 0);
        check("rst_buy_valid_p2", int'(buy_valid_p2), 0);
        check("rst_buy_code_p1", int'(buy_code_p1), 0);
        check("rst_buy_code_p2", int'(buy_code_p2), 0);
        check("rst_start_round", int'(start_round), 0);
        check("rst_done", int'(done), 0);
        check("rst_ok_count", int'(ok_count), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic acc;
        int   n_acc;
        int   snap;
        int   n;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_player = 1'b0; cmd_kind = 2'd0; cmd_code = 3'd0;
        phase_in = 1'b1; winner_in = 2'd0;
        purchase_success_p1 = 1'b1; purchase_success_p2 = 1'b0;
        err_no_inventory = 1'b0; err_wrong_distance = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;

        // BUY P1 code 0 in SHOP with success
        push(1'b0, 2'd1, 3'd0, 1'b1, acc);
        check("buy_accept", int'(acc), 1);
        wait_idle();
        check("buy_ok_count", int'(ok_count), 1);
        check("buy_err_count", int'(err_count), 0);

        // START then PLAY P2 code 1; drop phase two cycles after start_round
        push(1'b0, 2'd2, 3'd0, 1'b1, acc);
        push(1'b1, 2'd0, 3'd1, 1'b1, acc);
        n = 0;
        while (!start_round && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", int'(start_round), 1);
        repeat (2) @(negedge clk);
        phase_in = 1'b0;
        wait_idle();
        check("start_play_ok_count", int'(ok_count), 3);

        // PLAY held for 20 cycles while in SHOP
        phase_in = 1'b1;
        snap = strobe_cnt;
        push(1'b0, 2'd0, 3'd5, 1'b1, acc);
        repeat (20) @(negedge clk);
        check("held_fifo_count", int'(fifo_count), 1);
        check("held_no_strobe", strobe_cnt - snap, 0);
        phase_in = 1'b0;
        n = 0;
        while (!play_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("held_release_strobe", int'(play_valid), 1);
        wait_idle();
        check("held_ok_count", int'(ok_count), 4);

        // Fill FIFO with mismatched PLAYs, overflow attempt, then drain in order
        phase_in = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            push(1'(i), 2'd0, 3'(i), 1'b1, acc);
            n_acc += int'(acc);
        end
        check("fill_accepted", n_acc, 8);
        @(negedge clk);
        check("full_fifo_count", int'(fifo_count), 8);
        check("full_cmd_ready", int'(cmd_ready), 0);
        push(1'b1, 2'd0, 3'd7, 1'b0, acc);
        check("overflow_accept", int'(acc), 0);
        @(negedge clk);
        check("overflow_fifo_count", int'(fifo_count), 8);
        phase_in = 1'b0;
        wait_idle();
        check("drain_ok_count", int'(ok_count), 12);

        // PLAY with wrong distance, then a reserved-kind command
        err_wrong_distance = 1'b1;
        push(1'b0, 2'd0, 3'd2, 1'b1, acc);
        wait_idle();
        err_wrong_distance = 1'b0;
        check("play_err_count", int'(err_count), 1);
        snap = strobe_cnt;
        push(1'b0, 2'd3, 3'd6, 1'b0, acc);
        wait_idle();
        check("rsv_err_count", int'(err_count), 2);
        check("rsv_no_strobe", strobe_cnt - snap, 0);
        check("rsv_ok_count", int'(ok_count), 12);

        // Winner during RESP with 3 commands still queued
        phase_in = 1'b0;
        push(1'b1, 2'd1, 3'd7, 1'b1, acc);
        push(1'b0, 2'd0, 3'd1, 1'b0, acc);
        push(1'b1, 2'd0, 3'd2, 1'b0, acc);
        push(1'b0, 2'd0, 3'd3, 1'b0, acc);
        @(negedge clk);
        check("win_pre_fifo_count", int'(fifo_count), 4);
        phase_in = 1'b1;
        n = 0;
        while (!buy_valid_p2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("win_buy_seen", int'(buy_valid_p2), 1);
        @(posedge clk);
        #1;
        check("win_resp_fifo_count", int'(fifo_count), 3);
        winner_in = 2'd2;
        @(posedge clk);
        #1;
        check("win_done", int'(done), 1);
        check("win_fifo_count", int'(fifo_count), 0);
        check("win_cmd_ready", int'(cmd_ready), 0);
        winner_in = 2'd0;
        phase_in = 1'b0;
        snap = strobe_cnt;
        push(1'b0, 2'd0, 3'd4, 1'b0, acc);
        check("done_push_refused", int'(acc), 0);
        repeat (10) @(negedge clk);
        check("done_no_strobe", strobe_cnt - snap, 0);
        check("done_held", int'(done), 1);

        // Reset returns everything to its reset value
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(busy), 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_cmd_driver.md
# game_cmd_driver

Command sequencer that drives the fighting-game core's control inputs: turn, play strobe, per-player buy strobes and round start. It sits between a host command source (testbench, UART decoder or keypad scanner) and the game core. It buffers host commands in a FIFO, issues each one only when the core is in the matching phase, samples the core's response flags, and keeps success and error counters.

## Interface
- DEPTH, 8: command FIFO depth; power of two, at least 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  FIFO can accept; transfer occurs when valid & ready.
- cmd_player  in  1  0=P1, 1=P2.
- cmd_kind  in  2  0=PLAY, 1=BUY, 2=START, 3=reserved.
- cmd_code  in  3  action/buy code, passed through unmodified (5–7 allowed).
- phase_in  in  1  core phase: 0=PLAY, 1=SHOP.
- winner_in  in  2  core winner; nonzero ends the game.
- purchase_success_p1/p2  in  1  core shop success flags.
- err_no_inventory, err_wrong_distance  in  1  core play error flags.
- turn  out  1  active player for play strobe.
- play_valid  out  1  play strobe.
- play_action  out  3  play action code.
- buy_valid_p1, buy_valid_p2  out  1  buy strobes.
- buy_code_p1, buy_code_p2  out  3  buy codes.
- start_round  out  1  SHOP→PLAY request.
- busy  out  1  state ≠ IDLE or FIFO not empty.
- done  out  1  game over latched.
- ok_count, err_count  out  8  saturating result counters.
- fifo_count  out  clog2(DEPTH)+1  entries stored.

## Operation
- FIFO entries are {player, kind, code}. Read and write pointers are clog2(DEPTH) bits and wrap naturally. cmd_ready = !full && state≠DONE, so no push can occur when full.
- FSM states: IDLE, ISSUE, RESP, WAIT_PH, DONE.
- IDLE, head kind 3: pop it, increment err_count, stay in IDLE; nothing is driven to the core.
- IDLE, head PLAY with phase_in=0, BUY with phase_in=1, or START with phase_in=1: pop it and go to ISSUE.
- IDLE, phase mismatch: head is not popped; wait indefinitely.
- ISSUE, PLAY: play_valid=1, turn=player, play_action=code.
- ISSUE, BUY: buy_valid_pX=1 and buy_code_pX=code for the selected player only.
- ISSUE, START: start_round=1.
- ISSUE → RESP for PLAY and BUY. ISSUE → WAIT_PH for START.
- RESP, BUY: purchase_success of the issuing player=1 increments ok_count, otherwise err_count.
- RESP, PLAY: err_no_inventory|err_wrong_distance increments err_count, otherwise ok_count.
- RESP → IDLE.
- WAIT_PH: on phase_in=0, increment ok_count and go to IDLE.
- winner_in≠0 in any state: go to DONE on the next edge, overriding all other transitions. The FIFO is flushed (pointers cleared) and no further strobes are driven.
- DONE: done=1, cmd_ready=0. Exit only through rst.
- Counters saturate at 255 and do not wrap.
- turn holds its last issued value between commands. Codes hold their last value and are don't-care while their strobe is 0.

## Timing
- All outputs are registered except cmd_ready, busy and fifo_count, which are decoded from state and FIFO count.
- Reset values:
  - state IDLE, FIFO empty.
  - turn=0, play_valid=0, play_action=0.
  - buy_valid_p1/p2=0, buy_code_p1/p2=0.
  - start_round=0.
  - done=0, ok_count=0, err_count=0, fifo_count=0.
  - cmd_ready=1, busy=0.
- Reset mid-command aborts the command and drops all queued commands. No strobe is asserted on the first edge after reset release.
- A push into an empty FIFO is visible at the head on the next cycle. The earliest ISSUE is therefore 2 cycles after the push edge.
- Each strobe is high for exactly one cycle, the ISSUE cycle. The core samples it at the edge ending ISSUE.
- Response flags are sampled at the edge ending RESP, one cycle after the strobe.
- Throughput: PLAY and BUY take 3 cycles each (IDLE, ISSUE, RESP). START takes IDLE, ISSUE, and then at least one WAIT_PH cycle.
- A simultaneous push and pop when not full leaves fifo_count unchanged.

## Test plan
- Reset, push BUY P1 code 0 with phase_in=1 and purchase_success_p1=1 in RESP → buy_valid_p1 high for exactly 1 cycle, buy_code_p1=0, ok_count=1; buy_valid_p2 never asserts.
- Push START, then PLAY P2 code 1, with phase_in=1 → start_round pulses once. Set phase_in=0 two cycles later → ok_count+1; play_valid=1, turn=1, play_action=1 on the following ISSUE cycle.
- PLAY queued while phase_in=1 for 20 cycles → no strobe and fifo_count stays 1. Set phase_in=0 → strobe issued 2 cycles later.
- Push 8 commands with phase mismatched → cmd_ready=0 once fifo_count=8; a 9th push is not accepted. Set phase matching → all 8 issue in order, wrapping the pointers.
- PLAY with err_wrong_distance=1 in RESP → err_count=1. Kind-3 command → err_count=2, no strobe.
- winner_in=2 asserted during RESP with 3 commands queued → done=1 and fifo_count=0 on the next edge, no further strobes; rst returns every output to its reset value.
